cordic_job_arbiter: RTL and testbench

CORDIC_JOB_ARBITER -- requirements
Module: cordic_job_arbiter

---
 rtl/cordic_arb_pkg.sv | 15 +
 rtl/cordic_rr_arb.sv | 22 ++
 rtl/cordic_job_arbiter.sv | 160 ++++++++++++++++
 tb/tb_cordic_job_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_arb_pkg.sv
// Shared constants and types for the two-requester CORDIC job arbiter.
package cordic_arb_pkg;

   localparam int NREQ   = 2;
   localparam int DW_DEF = 16;
   localparam int LAT_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

endpackage

// File: rtl/cordic_rr_arb.sv
// Two-way round-robin grant: with both requesters pending, the one not granted last wins.
module cordic_rr_arb
   import cordic_arb_pkg::*;
(
   input  logic [NREQ-1:0] req_valid,
   input  logic            last_grant,
   output logic            gnt_vld,
   output logic            gnt_idx
);

   always_comb begin
      gnt_vld = |req_valid;
      gnt_idx = 1'b0;
      case (req_valid)
         2'b01:   gnt_idx = 1'b0;
         2'b10:   gnt_idx = 1'b1;
         2'b11:   gnt_idx = ~last_grant;
         default: gnt_idx = 1'b0;
      endcase
   end

endmodule

// File: rtl/cordic_job_arbiter.sv
// Shares one ap_ctrl_hs CORDIC core between two requesters, one job in flight,
// with issue-to-done latency reporting and a sticky hang-abort flag.
module cordic_job_arbiter
   import cordic_arb_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = 255
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*DW-1:0]   req_x,
   input  logic [NREQ*DW-1:0]   req_y,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [DW-1:0]        rsp_r,
   output logic [DW-1:0]        rsp_theta,
   output logic                 core_ap_start,
   input  logic                 core_ap_ready,
   input  logic                 core_ap_done,
   output logic [DW-1:0]        core_x,
   output logic [DW-1:0]        core_y,
   input  logic [DW-1:0]        core_r,
   input  logic [DW-1:0]        core_theta,
   output logic [LAT_W-1:0]     last_latency,
   output logic                 timeout_err
);

   localparam logic [LAT_W:0] TO_LIM = (LAT_W+1)'(TIMEOUT);

   function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

   state_e           state_q, state_d;
   logic             grant_q, grant_d;
   logic             last_q, last_d;
   logic [DW-1:0]    x_q, x_d, y_q, y_d;
   logic [DW-1:0]    r_q, r_d, th_q, th_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic [LAT_W-1:0] last_lat_q, last_lat_d;
   logic             terr_q, terr_d;

   logic             gnt_vld, gnt_idx;
   logic [LAT_W-1:0] lat_nxt;
   logic             timeout_hit;

   cordic_rr_arb u_arb (
      .req_valid  (req_valid),
      .last_grant (last_q),
      .gnt_vld    (gnt_vld),
      .gnt_idx    (gnt_idx)
   );

   // lat_nxt counts the current cycle, so a done seen now reports it inclusively
   assign lat_nxt     = sat_inc(lat_q);
   assign timeout_hit = ({1'b0, lat_nxt} >= TO_LIM);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      x_d        = x_q;
      y_d        = y_q;
      r_d        = r_q;
      th_d       = th_q;
      lat_d      = lat_q;
      last_lat_d = last_lat_q;
      terr_d     = terr_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_vld) begin
               grant_d = gnt_idx;
               x_d     = gnt_idx ? req_x[DW +: DW] : req_x[0 +: DW];
               y_d     = gnt_idx ? req_y[DW +: DW] : req_y[0 +: DW];
               lat_d   = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            lat_d = lat_nxt;
            if (core_ap_ready && core_ap_done) begin
               r_d        = core_r;
               th_d       = core_theta;
               last_lat_d = lat_nxt;
               state_d    = ST_RESP;
            end else if (timeout_hit) begin
               terr_d  = 1'b1;
               last_d  = grant_q;
               state_d = ST_IDLE;
            end else if (core_ap_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            lat_d = lat_nxt;
            if (core_ap_done) begin
               r_d        = core_r;
               th_d       = core_theta;
               last_lat_d = lat_nxt;
               state_d    = ST_RESP;
            end else if (timeout_hit) begin
               terr_d  = 1'b1;
               last_d  = grant_q;
               state_d = ST_IDLE;
            end
         end
         ST_RESP: begin
            if (rsp_ready[grant_q]) begin
               last_d  = grant_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         grant_q    <= 1'b0;
         last_q     <= 1'b1;
         x_q        <= '0;
         y_q        <= '0;
         r_q        <= '0;
         th_q       <= '0;
         lat_q      <= '0;
         last_lat_q <= '0;
         terr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         x_q        <= x_d;
         y_q        <= y_d;
         r_q        <= r_d;
         th_q       <= th_d;
         lat_q      <= lat_d;
         last_lat_q <= last_lat_d;
         terr_q     <= terr_d;
      end
   end

   // req_ready is combinational from req_valid, so it is masked while reset is held
   assign req_ready     = (state_q == ST_IDLE && gnt_vld && !reset) ? onehot(gnt_idx) : '0;
   assign rsp_valid     = (state_q == ST_RESP) ? onehot(grant_q) : '0;
   assign core_ap_start = (state_q == ST_ISSUE);
   assign core_x        = x_q;
   assign core_y        = y_q;
   assign rsp_r         = r_q;
   assign rsp_theta     = th_q;
   assign last_latency  = last_lat_q;
   assign timeout_err   = terr_q;

endmodule

// File: tb/tb_cordic_job_arbiter.sv
// Directed, table-driven bench for cordic_job_arbiter; the CORDIC core is played
// cycle by cycle from the stimulus thread.
module tb_cordic_job_arbiter;

   localparam int DW = 16;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [1:0]      req_valid = '0;
   logic [1:0]      req_ready;
   logic [2*DW-1:0] req_x = '0;
   logic [2*DW-1:0] req_y = '0;
   logic [1:0]      rsp_valid;
   logic [1:0]      rsp_ready = '0;
   logic [DW-1:0]   rsp_r, rsp_theta;
   logic            core_ap_start;
   logic            core_ap_ready = 1'b0;
   logic            core_ap_done = 1'b0;
   logic [DW-1:0]   core_x, core_y;
   logic [DW-1:0]   core_r = '0;
   logic [DW-1:0]   core_theta = '0;
   logic [15:0]     last_latency;
   logic            timeout_err;

   int total = 0;
   int bad   = 0;

   cordic_job_arbiter #(.DW(DW), .TIMEOUT(255)) dut (
      .clock         (clock),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_x         (req_x),
      .req_y         (req_y),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_r         (rsp_r),
      .rsp_theta     (rsp_theta),
      .core_ap_start (core_ap_start),
      .core_ap_ready (core_ap_ready),
      .core_ap_done  (core_ap_done),
      .core_x        (core_x),
      .core_y        (core_y),
      .core_r        (core_r),
      .core_theta    (core_theta),
      .last_latency  (last_latency),
      .timeout_err   (timeout_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          rst;
      logic [1:0]  rv;
      logic [15:0] x0, y0, x1, y1;
      int          rdy;
      int          done;
      logic [15:0] r, th;
      int          bp;
      int          g;
      logic [15:0] lat;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".req_ready"},     req_ready, 2'b00);
      chk({tag, ".rsp_valid"},     rsp_valid, 2'b00);
      chk({tag, ".rsp_r"},         rsp_r, 16'h0);
      chk({tag, ".rsp_theta"},     rsp_theta, 16'h0);
      chk({tag, ".core_ap_start"}, core_ap_start, 1'b0);
      chk({tag, ".core_x"},        core_x, 16'h0);
      chk({tag, ".core_y"},        core_y, 16'h0);
      chk({tag, ".last_latency"},  last_latency, 16'h0);
      chk({tag, ".timeout_err"},   timeout_err, 1'b0);
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset = 1'b1;
      req_valid = '0; rsp_ready = '0; core_ap_ready = 0; core_ap_done = 0;
      @(negedge clock);
      #1 chk_reset_vals("rst");
      @(negedge clock);
      reset = 1'b0;
   endtask

   // One complete job: request, core handshake, optional back-pressure, accept.
   task automatic do_job(input vec_t v, input string tag);
      logic [1:0]  gm;
      logic [15:0] ex, ey;
      gm = (v.g == 1) ? 2'b10 : 2'b01;
      ex = (v.g == 1) ? v.x1 : v.x0;
      ey = (v.g == 1) ? v.y1 : v.y0;
      @(negedge clock);
      req_valid = v.rv;
      req_x = {v.x1, v.x0};
      req_y = {v.y1, v.y0};
      #1 chk({tag, ".grant"}, req_ready, gm);
      for (int c = 1; c <= v.done; c++) begin
         @(negedge clock);
         req_x = ~{v.x1, v.x0};
         req_y = ~{v.y1, v.y0};
         core_ap_ready = (c == v.rdy + 1);
         core_ap_done  = (c == v.done);
         core_r        = (c == v.done) ? v.r  : 16'hDEAD;
         core_theta    = (c == v.done) ? v.th : 16'hBEEF;
         #1;
         if (c <= v.rdy + 1)
            chk($sformatf("%s.issue_c%0d", tag, c), {core_ap_start, core_x, core_y}, {1'b1, ex, ey});
         else
            chk($sformatf("%s.wait_c%0d", tag, c), core_ap_start, 1'b0);
         chk($sformatf("%s.busy_rdy_c%0d", tag, c), req_ready, 2'b00);
      end
      for (int k = 0; k <= v.bp; k++) begin
         @(negedge clock);
         if (k == 0) begin
            core_ap_ready = 0; core_ap_done = 0;
            core_r = 16'h5A5A; core_theta = 16'hA5A5;
         end
         if (k < v.bp) begin
            rsp_ready = ~gm; req_valid = 2'b11;
         end else begin
            rsp_ready = gm;  req_valid = 2'b00;
         end
         #1;
         chk($sformatf("%s.rsp_valid_k%0d", tag, k), rsp_valid, gm);
         chk($sformatf("%s.rsp_data_k%0d", tag, k), {rsp_r, rsp_theta}, {v.r, v.th});
         chk($sformatf("%s.resp_rdy_k%0d", tag, k), req_ready, 2'b00);
      end
      chk({tag, ".last_latency"}, last_latency, v.lat);
      @(negedge clock);
      rsp_ready = '0;
      #1 chk({tag, ".rsp_drop"}, rsp_valid, 2'b00);
   endtask

   initial begin
      int quiet_bad;
      vecs[0] = '{1'b1, 2'b01, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 0, 20, 16'h0100, 16'h0000, 0, 0, 16'd20};
      vecs[1] = '{1'b1, 2'b11, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 3, 16'hAAAA, 16'h5555, 0, 0, 16'd3};
      vecs[2] = '{1'b0, 2'b11, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 5, 16'h1234, 16'h8765, 0, 1, 16'd5};
      vecs[3] = '{1'b0, 2'b11, 16'h0F0F, 16'h0E0E, 16'h0D0D, 16'h0C0C, 0, 2, 16'h0001, 16'h0002, 0, 0, 16'd2};
      vecs[4] = '{1'b0, 2'b11, 16'h0F0F, 16'h0E0E, 16'h0D0D, 16'h0C0C, 0, 4, 16'hFFFF, 16'h8000, 0, 1, 16'd4};
      vecs[5] = '{1'b0, 2'b10, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 2, 6, 16'h7FFF, 16'h1921, 10, 1, 16'd6};
      vecs[6] = '{1'b0, 2'b11, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 0, 1, 16'h0005, 16'h0927, 0, 0, 16'd1};
      vecs[7] = '{1'b0, 2'b01, 16'h0100, 16'h0100, 16'h0200, 16'h0200, 1, 7, 16'h016A, 16'h0C90, 2, 0, 16'd7};
      vecs[8] = '{1'b0, 2'b11, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 0, 3, 16'h1111, 16'h2222, 1, 0, 16'd3};
      vecs[9] = '{1'b0, 2'b11, 16'h4000, 16'hC000, 16'h0001, 16'hFFFF, 1, 4, 16'h0246, 16'h8642, 0, 0, 16'd4};

      repeat (2) @(negedge clock);
      #1 chk_reset_vals("por");
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].rst) apply_reset();
         do_job(vecs[i], $sformatf("v%0d", i));
      end

      // Hung core: requester 1 wins, core never finishes, job is dropped.
      @(negedge clock);
      req_valid = 2'b11;
      req_x = {16'h0202, 16'h0101};
      req_y = {16'h0404, 16'h0303};
      #1 chk("hang.grant", req_ready, 2'b10);
      quiet_bad = 0;
      for (int c = 1; c <= 255; c++) begin
         @(negedge clock);
         req_valid = 2'b00;
         core_ap_ready = (c == 1);
         core_ap_done = 1'b0;
         #1;
         if (rsp_valid !== 2'b00 || timeout_err !== 1'b0) quiet_bad++;
      end
      chk("hang.quiet", quiet_bad, 0);
      @(negedge clock);
      #1;
      chk("hang.timeout_err", timeout_err, 1'b1);
      chk("hang.no_rsp", rsp_valid, 2'b00);
      chk("hang.start_low", core_ap_start, 1'b0);
      do_job(vecs[8], "after_hang");
      chk("hang.sticky", timeout_err, 1'b1);

      // Reset while waiting on the core.
      @(negedge clock);
      req_valid = 2'b01;
      req_x = {16'h2468, 16'h1357};
      req_y = {16'h8642, 16'h7531};
      #1 chk("rstw.grant", req_ready, 2'b01);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clock);
         req_valid = 2'b00;
         core_ap_ready = (c == 1);
         #1;
      end
      chk("rstw.in_wait", core_ap_start, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      req_valid = 2'b11;
      core_ap_ready = 1'b0;
      #1 chk_reset_vals("rstw");
      @(negedge clock);
      reset = 1'b0;
      req_valid = 2'b00;
      core_ap_done = 1'b1;
      core_r = 16'hFFFF;
      quiet_bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         core_ap_done = 1'b0;
         #1;
         if (rsp_valid !== 2'b00 || core_ap_start !== 1'b0) quiet_bad++;
      end
      chk("rstw.no_stale", quiet_bad, 0);
      do_job(vecs[9], "after_rstw");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
